// File: rtl/primegen.sv
// primegen: sequential prime-number generator.
// After reset res=1. Each accepted go advances res to the next prime.
// Primes are found by trial division against odd divisors. The remainder is
// formed by repeated subtraction, so the block needs no divider.
// Candidate and divisor arithmetic is WIDTH+1 bits wide. This lets a candidate
// that has run past 2^WIDTH-1 be seen and flagged as overflow.
// Optional feature: define PRIMEGEN_SMALL_TABLE_EN to step through primes below
// 31 from a constant table (2-cycle latency). Trial division is then used only
// from 31 upward. The output sequence is the same either way.

module primegen #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             go,
    output logic             ready,
    output logic             error,
    output logic [WIDTH-1:0] res
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_TEST,
        S_DIV,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [WIDTH:0] MAX_CAND = {1'b0, {WIDTH{1'b1}}};
    localparam logic [WIDTH:0] C_ONE    = (WIDTH+1)'(1);
    localparam logic [WIDTH:0] C_TWO    = (WIDTH+1)'(2);
    localparam logic [WIDTH:0] C_THREE  = (WIDTH+1)'(3);
    localparam logic [WIDTH:0] C_FOUR   = (WIDTH+1)'(4);
    localparam logic [WIDTH:0] C_NINE   = (WIDTH+1)'(9);

    state_t         state;
    logic [WIDTH:0] cand;   // candidate under test
    logic [WIDTH:0] d;      // current odd trial divisor
    logic [WIDTH:0] dsq;    // d*d, kept incrementally
    logic [WIDTH:0] rem;    // running remainder of cand / d
    logic [WIDTH:0] res_ext;

    assign res_ext = {1'b0, res};

`ifdef PRIMEGEN_SMALL_TABLE_EN
    // Successor of each small prime. The value 1 maps to 2 so that the
    // sequence starts from the reset value.
    function automatic int small_next(input int r);
        case (r)
            1:       return 2;
            2:       return 3;
            3:       return 5;
            5:       return 7;
            7:       return 11;
            11:      return 13;
            13:      return 17;
            17:      return 19;
            19:      return 23;
            23:      return 29;
            29:      return 31;
            default: return 0;
        endcase
    endfunction
`endif

    // Control FSM and datapath. All outputs are registered here.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // register samples the pre-edge values of the others.
        if (rst) begin
            // NOTE: the datapath registers are cleared as well. They are a
            // handful of flops, and clearing them keeps simulation free of X.
            state <= S_IDLE;
            res   <= {{(WIDTH-1){1'b0}}, 1'b1};
            ready <= 1'b1;
            error <= 1'b0;
            cand  <= '0;
            d     <= '0;
            dsq   <= '0;
            rem   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (go && !error) begin
                        ready <= 1'b0;
`ifdef PRIMEGEN_SMALL_TABLE_EN
                        if (res_ext < (WIDTH+1)'(31)) begin
                            cand  <= (WIDTH+1)'(small_next(int'(res)));
                            state <= S_DONE;
                        end else begin
                            cand  <= res_ext + C_TWO;
                            state <= S_CHECK;
                        end
`else
                        if (res_ext == C_ONE) begin
                            cand  <= C_TWO;
                            state <= S_DONE;
                        end else if (res_ext == C_TWO) begin
                            cand  <= C_THREE;
                            state <= S_DONE;
                        end else begin
                            cand  <= res_ext + C_TWO;
                            state <= S_CHECK;
                        end
`endif
                    end
                end

                S_CHECK: begin
                    if (cand > MAX_CAND) begin
                        error <= 1'b1;
                        ready <= 1'b1;
                        state <= S_ERR;
                    end else begin
                        d     <= C_THREE;
                        dsq   <= C_NINE;
                        state <= S_TEST;
                    end
                end

                S_TEST: begin
                    // No divisor up to sqrt(cand) divides it, so cand is prime.
                    if (dsq > cand) begin
                        state <= S_DONE;
                    end else begin
                        rem   <= cand;
                        state <= S_DIV;
                    end
                end

                S_DIV: begin
                    if (rem >= d) begin
                        rem <= rem - d;
                    end else if (rem == '0) begin
                        cand  <= cand + C_TWO;
                        state <= S_CHECK;
                    end else begin
                        // (d+2)^2 = d^2 + 4d + 4
                        d     <= d + C_TWO;
                        dsq   <= dsq + (d << 2) + C_FOUR;
                        state <= S_TEST;
                    end
                end

                S_DONE: begin
                    res   <= cand[WIDTH-1:0];
                    ready <= 1'b1;
                    state <= S_IDLE;
                end

                S_ERR: begin
                    state <= S_ERR;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_primegen.sv
// Self-checking bench for primegen.
// The WIDTH=16 instance is checked against a table of the first eleven primes,
// against go being ignored while busy, against go held high, and against a
// reset during a computation.
// A WIDTH=8 instance is walked through every 8-bit prime to reach overflow
// quickly, since the 16-bit overflow point is too far away to reach.
// Expected primes come from a bench-side trial-division model through a
// scoreboard queue.

module tb_primegen;

    localparam int BOUND = 4000;

    logic        clk = 1'b0;
    logic        rst, go, ready, error;
    logic [15:0] res;
    logic        rst8, go8, ready8, error8;
    logic [7:0]  res8;

    int n_checks = 0;
    int n_errors = 0;
    int exp_q[$];

    typedef struct {
        int exp_res;
        int lat_min;
        int lat_max;
    } vec_t;

    vec_t vec[11];

    always #5 clk = ~clk;

    primegen #(.WIDTH(16)) dut (
        .clk   (clk),
        .rst   (rst),
        .go    (go),
        .ready (ready),
        .error (error),
        .res   (res)
    );

    primegen #(.WIDTH(8)) dut8 (
        .clk   (clk),
        .rst   (rst8),
        .go    (go8),
        .ready (ready8),
        .error (error8),
        .res   (res8)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic bit is_prime(input int c);
        if (c < 2) return 1'b0;
        for (int k = 2; k * k <= c; k++)
            if (c % k == 0) return 1'b0;
        return 1'b1;
    endfunction

    function automatic int next_prime(input int p);
        int c;
        c = p + 1;
        while (!is_prime(c)) c++;
        return c;
    endfunction

    // One go pulse on the 16-bit instance: check the result and the latency.
    task automatic step16(input int exp_res, input int lat_min, input int lat_max);
        int lat;
        int e;
        check($sformatf("ready_before_go_%0d", exp_res), 32'(ready), 1);
        exp_q.push_back(exp_res);
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        lat = 1;
        while (ready !== 1'b1 && lat < BOUND) begin
            @(negedge clk);
            lat++;
        end
        check($sformatf("ready_after_go_%0d", exp_res), 32'(ready), 1);
        e = exp_q.pop_front();
        check($sformatf("res_step_%0d", exp_res), 32'(res), e);
        check($sformatf("latency_in_range_%0d(lat=%0d)", exp_res, lat),
              32'(lat >= lat_min && lat <= lat_max), 1);
        check($sformatf("no_error_%0d", exp_res), 32'(error), 0);
    endtask

    // One go pulse on the 8-bit instance.
    task automatic step8(input int exp_res);
        int lat;
        int e;
        exp_q.push_back(exp_res);
        go8 = 1'b1;
        @(negedge clk);
        go8 = 1'b0;
        lat = 1;
        while (ready8 !== 1'b1 && lat < BOUND) begin
            @(negedge clk);
            lat++;
        end
        e = exp_q.pop_front();
        check($sformatf("w8_res_step_%0d", exp_res), 32'(res8), e);
        check($sformatf("w8_no_error_%0d", exp_res), 32'(error8), 0);
    endtask

    task automatic reset16();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int p;
        int e;
        int cyc;

`ifdef PRIMEGEN_SMALL_TABLE_EN
        vec[0]  = '{2, 2, 2};   vec[1]  = '{3, 2, 2};   vec[2]  = '{5, 2, 2};
        vec[3]  = '{7, 2, 2};   vec[4]  = '{11, 2, 2};  vec[5]  = '{13, 2, 2};
        vec[6]  = '{17, 2, 2};  vec[7]  = '{19, 2, 2};  vec[8]  = '{23, 2, 2};
        vec[9]  = '{29, 2, 2};  vec[10] = '{31, 2, 2};
`else
        vec[0]  = '{2, 2, 2};   vec[1]  = '{3, 2, 2};   vec[2]  = '{5, 4, 60};
        vec[3]  = '{7, 4, 60};  vec[4]  = '{11, 4, 60}; vec[5]  = '{13, 4, 60};
        vec[6]  = '{17, 4, 60}; vec[7]  = '{19, 4, 60}; vec[8]  = '{23, 4, 60};
        vec[9]  = '{29, 4, 60}; vec[10] = '{31, 4, 60};
`endif

        rst  = 1'b1;
        rst8 = 1'b1;
        go   = 1'b0;
        go8  = 1'b0;
        @(negedge clk);
        rst  = 1'b0;
        rst8 = 1'b0;

        // Reset state
        repeat (100) @(negedge clk);
        check("reset_ready", 32'(ready), 1);
        check("reset_error", 32'(error), 0);
        check("reset_res", 32'(res), 1);

        // Main sequence, table driven
        for (int i = 0; i < 11; i++) begin
            step16(vec[i].exp_res, vec[i].lat_min, vec[i].lat_max);
            repeat (100) @(negedge clk);
        end

        // A go pulse while busy is dropped, not queued
        reset16();
        for (int i = 0; i < 9; i++) step16(vec[i].exp_res, vec[i].lat_min, vec[i].lat_max);
        check("busy_start_res", 32'(res), 23);
        exp_q.push_back(29);
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
`ifndef PRIMEGEN_SMALL_TABLE_EN
        @(negedge clk);
`endif
        check("busy_ready_low", 32'(ready), 0);
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        cyc = 0;
        while (ready !== 1'b1 && cyc < BOUND) begin
            @(negedge clk);
            cyc++;
        end
        e = exp_q.pop_front();
        check("busy_res", 32'(res), e);
        repeat (80) @(negedge clk);
        check("busy_not_queued_res", 32'(res), 29);
        check("busy_not_queued_ready", 32'(ready), 1);

        // Reset during a computation
        reset16();
        for (int i = 0; i < 6; i++) step16(vec[i].exp_res, vec[i].lat_min, vec[i].lat_max);
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midreset_res", 32'(res), 1);
        check("midreset_ready", 32'(ready), 1);
        check("midreset_error", 32'(error), 0);

        // go held high restarts every time the block returns to idle
        for (int i = 0; i < 4; i++) exp_q.push_back(vec[i].exp_res);
        go = 1'b1;
        cyc = 0;
        while (exp_q.size() > 0 && cyc < BOUND) begin
            @(negedge clk);
            cyc++;
            if (ready === 1'b1) begin
                e = exp_q.pop_front();
                check($sformatf("hold_go_res_%0d", e), 32'(res), e);
                if (exp_q.size() == 0) go = 1'b0;
            end
        end
        go = 1'b0;
        check("hold_go_all_seen", 32'(exp_q.size()), 0);
        exp_q.delete();
        repeat (80) @(negedge clk);
        check("hold_go_release_res", 32'(res), 7);

        // Overflow on the 8-bit instance
        check("w8_reset_res", 32'(res8), 1);
        p = 1;
        while (next_prime(p) <= 255) begin
            p = next_prime(p);
            step8(p);
        end
        check("w8_last_prime", 32'(res8), 251);
        go8 = 1'b1;
        @(negedge clk);
        go8 = 1'b0;
        cyc = 0;
        while (ready8 !== 1'b1 && cyc < BOUND) begin
            @(negedge clk);
            cyc++;
        end
        check("w8_ovf_error", 32'(error8), 1);
        check("w8_ovf_ready", 32'(ready8), 1);
        check("w8_ovf_res", 32'(res8), 251);
        go8 = 1'b1;
        @(negedge clk);
        go8 = 1'b0;
        repeat (50) @(negedge clk);
        check("w8_ovf_sticky_error", 32'(error8), 1);
        check("w8_ovf_sticky_ready", 32'(ready8), 1);
        check("w8_ovf_sticky_res", 32'(res8), 251);
        rst8 = 1'b1;
        @(negedge clk);
        rst8 = 1'b0;
        check("w8_rst_res", 32'(res8), 1);
        check("w8_rst_error", 32'(error8), 0);
        check("w8_rst_ready", 32'(ready8), 1);
        step8(2);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
